// File: rtl/lane_buffer_arbiter.sv
// Round-robin arbiter sharing one WIDTH-lane inverting buffer bank between NUM_REQ requesters.
// Optional per-grant beat limit enabled by defining LANE_ARB_BURST_LIMIT_EN.
module lane_buffer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [2:0]               out_owner
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_param_check
    $error("lane_buffer_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_valid_q;
  logic [2:0]         out_owner_q;

  logic [WIDTH-1:0]   sel_slice;
  logic [WIDTH-1:0]   out_data_d;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               beat_acc;
  logic               beat_last;

  // First requester at or after ptr+1, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!pick_found && req[IDX_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    sel_slice = req_data[int'(owner_q)*WIDTH +: WIDTH];
  end

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    assign out_data_d[l] = ~sel_slice[l];
  end

  assign beat_acc = (state_q == BUSY) && req[owner_q] && gnt_q[owner_q];

`ifdef LANE_ARB_BURST_LIMIT_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] beat_cnt_q;

  assign beat_last = req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      beat_cnt_q <= '0;
    end else if (beat_acc) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end
`else
  assign beat_last = req_last[owner_q];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (pick_found) begin
            gnt_q   <= NUM_REQ'(1) << pick_idx;
            owner_q <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (beat_acc) begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            out_owner_q <= 3'(owner_q);
            if (beat_last) begin
              ptr_q   <= owner_q;
              gnt_q   <= '0;
              state_q <= IDLE;
            end
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_owner = out_owner_q;

endmodule

// File: tb/tb_lane_buffer_arbiter.sv
// Directed self-checking bench for lane_buffer_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_lane_buffer_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [2:0]  out_owner;

  int checks;
  int errors;

  lane_buffer_arbiter #(
    .NUM_REQ  (4),
    .WIDTH    (8),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .gnt      (gnt),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_owner(out_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    req_last = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_owner", 32'(out_owner), 32'h0);

    // single-beat burst from requester 0
    req      = 4'b0001;
    req_data = 32'h0000_00AA;
    req_last = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_valid0", 32'(out_valid), 32'h0);
    tick();
    check("t1_data", 32'(out_data), 32'h55);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_owner", 32'(out_owner), 32'h0);
    check("t1_gnt_rel", 32'(gnt), 32'h0);
    req      = '0;
    req_last = '0;
    tick();
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    check("t1_idle_gnt", 32'(gnt), 32'h0);

    // round robin of single-beat bursts
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h0302_0100;
    req_last = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = n % 4;
      tick();
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << k));
      check("rr_dead", 32'(out_valid), 32'h0);
      tick();
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_data", 32'(out_data), 32'(8'hFF ^ 8'(k)));
      check("rr_owner", 32'(out_owner), 32'(k));
      check("rr_gnt_rel", 32'(gnt), 32'h0);
    end

    // multi-beat burst from requester 2 with a stall, requester 0 waiting
    req      = 4'b0101;
    req_data = 32'h0000_0000;
    req_last = 4'b0000;
    tick();
    check("mb_gnt", 32'(gnt), 32'h4);
    tick();
    check("mb_b0_data", 32'(out_data), 32'hFF);
    check("mb_b0_valid", 32'(out_valid), 32'h1);
    check("mb_b0_owner", 32'(out_owner), 32'h2);
    req = 4'b0001;
    tick();
    check("mb_stall_valid", 32'(out_valid), 32'h0);
    check("mb_stall_gnt", 32'(gnt), 32'h4);
    req      = 4'b0101;
    req_data = 32'h00F0_0000;
    tick();
    check("mb_b1_data", 32'(out_data), 32'h0F);
    check("mb_b1_valid", 32'(out_valid), 32'h1);
    req_data = 32'h000F_0000;
    req_last = 4'b0100;
    tick();
    check("mb_b2_data", 32'(out_data), 32'hF0);
    check("mb_b2_owner", 32'(out_owner), 32'h2);
    check("mb_rel_gnt", 32'(gnt), 32'h0);
    req      = 4'b0001;
    req_last = 4'b0000;
    tick();
    check("mb_next_gnt", 32'(gnt), 32'h1);

    // reset on the second beat of a burst from requester 0
    req_data = 32'h0000_0011;
    tick();
    check("rb_b0_data", 32'(out_data), 32'hEE);
    check("rb_b0_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    tick();
    check("rb_gnt", 32'(gnt), 32'h0);
    check("rb_data", 32'(out_data), 32'h0);
    check("rb_valid", 32'(out_valid), 32'h0);
    check("rb_owner", 32'(out_owner), 32'h0);
    reset = 1'b0;
    req   = 4'b0110;
    tick();
    check("rb_regrant", 32'(gnt), 32'h2);

    // requester 1 streams without req_last
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    req      = 4'b0010;
    req_data = 32'h0000_3300;
    req_last = 4'b0000;
    tick();
    check("st_gnt", 32'(gnt), 32'h2);
`ifdef LANE_ARB_BURST_LIMIT_EN
    for (int b = 1; b <= 4; b++) begin
      tick();
      check("lim_valid", 32'(out_valid), 32'h1);
      check("lim_data", 32'(out_data), 32'hCC);
      check("lim_gnt", 32'(gnt), (b == 4) ? 32'h0 : 32'h2);
    end
    tick();
    check("lim_dead_valid", 32'(out_valid), 32'h0);
    check("lim_regrant", 32'(gnt), 32'h2);
    tick();
    check("lim_resume", 32'(out_valid), 32'h1);
`else
    for (int b = 0; b < 22; b++) begin
      tick();
      check("unl_gnt", 32'(gnt), 32'h2);
      check("unl_valid", 32'(out_valid), 32'h1);
      check("unl_data", 32'(out_data), 32'hCC);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
